sfifo_lvl: RTL



---
 rtl/sfifo_lvl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/sfifo_lvl.sv
// Synchronous FIFO with level reporting, almost-full/empty thresholds,
// sticky overflow/underflow flags, flush, and selectable FWFT or registered read.
module sfifo_lvl #(
  parameter int unsigned abits      = 3,
  parameter int unsigned dbits      = 65,
  parameter int          afull_lvl  = 6,
  parameter int          aempty_lvl = 1,
  parameter int          fwft       = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_wr,
  input  logic [dbits-1:0] i_wdata,
  output logic             o_wfull,
  output logic             o_afull,
  input  logic             i_rd,
  output logic [dbits-1:0] o_rdata,
  output logic             o_rvalid,
  output logic             o_rempty,
  output logic             o_aempty,
  output logic [abits:0]   o_level,
  output logic             o_overflow,
  output logic             o_underflow,
  input  logic             i_clr_err
);

  localparam int unsigned DEPTH = 2 ** abits;
  localparam int unsigned LW    = abits + 1;

  localparam logic [abits:0] LVL_FULL   = LW'(DEPTH);
  localparam logic [abits:0] LVL_AFULL  = LW'(afull_lvl);
  localparam logic [abits:0] LVL_AEMPTY = LW'(aempty_lvl);
  localparam logic [abits:0] LVL_ONE    = LW'(1);

  // Threshold sanity: reject configurations the flags cannot represent
  if (afull_lvl < 1 || afull_lvl > int'(DEPTH)) begin : g_bad_afull
    $error("sfifo_lvl: afull_lvl out of range 1..DEPTH");
  end
  if (aempty_lvl < 0 || aempty_lvl > int'(DEPTH) - 1) begin : g_bad_aempty
    $error("sfifo_lvl: aempty_lvl out of range 0..DEPTH-1");
  end

  logic [dbits-1:0] mem [DEPTH];
  logic [abits:0]   wr_ptr;
  logic [abits:0]   rd_ptr;
  logic [abits:0]   level_nxt;
  logic             wr_ok;
  logic             rd_ok;
  logic             ovf_set;
  logic             unf_set;

  assign wr_ok   = i_wr && !o_wfull  && !i_flush;
  assign rd_ok   = i_rd && !o_rempty && !i_flush;
  assign ovf_set = i_wr && o_wfull   && !i_flush;
  assign unf_set = i_rd && o_rempty  && !i_flush;

  // Next level: both or neither strobes leave the count unchanged
  always_comb begin
    level_nxt = o_level;
    if (i_flush) begin
      level_nxt = '0;
    end else if (wr_ok && !rd_ok) begin
      level_nxt = o_level + LVL_ONE;
    end else if (rd_ok && !wr_ok) begin
      level_nxt = o_level - LVL_ONE;
    end
  end

  // Pointers and all level-derived flags, updated together
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      o_level  <= '0;
      o_wfull  <= 1'b0;
      o_afull  <= 1'b0;
      o_rempty <= 1'b1;
      o_aempty <= 1'b1;
    end else begin
      if (i_flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_ok) wr_ptr <= wr_ptr + LVL_ONE;
        if (rd_ok) rd_ptr <= rd_ptr + LVL_ONE;
      end
      o_level  <= level_nxt;
      o_wfull  <= (level_nxt == LVL_FULL);
      o_afull  <= (level_nxt >= LVL_AFULL);
      o_rempty <= (level_nxt == '0);
      o_aempty <= (level_nxt <= LVL_AEMPTY);
    end
  end

  // Sticky error flags; a new error in the clear cycle wins
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      if (ovf_set)        o_overflow <= 1'b1;
      else if (i_clr_err) o_overflow <= 1'b0;
      if (unf_set)        o_underflow <= 1'b1;
      else if (i_clr_err) o_underflow <= 1'b0;
    end
  end

  // Storage array, deliberately without reset
  always_ff @(posedge i_clk) begin
    if (wr_ok) mem[wr_ptr[abits-1:0]] <= i_wdata;
  end

  if (fwft != 0) begin : g_fwft
    assign o_rdata  = mem[rd_ptr[abits-1:0]];
    assign o_rvalid = !o_rempty;
  end else begin : g_regrd
    logic [dbits-1:0] rdata_q;
    logic             rvalid_q;

    // Head word captured on each accepted read, held otherwise
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
      end else begin
        rvalid_q <= rd_ok;
        if (rd_ok) rdata_q <= mem[rd_ptr[abits-1:0]];
      end
    end

    assign o_rdata  = rdata_q;
    assign o_rvalid = rvalid_q;
  end

endmodule
